// File: rtl/dest_tag_pipeline_if.sv
// Hazard-interface bundle between decode/hazard unit (master) and the dest-tag pipeline (slave).
// Carries the decode-stage entry, stall/flush controls, stage tags and the monitoring outputs.
interface dest_tag_pipeline_if #(
  parameter int TAG_W = 4,
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic             id_writes;
  logic [TAG_W-1:0] id_dest;
  logic             stall;
  logic             flush;
  logic [TAG_W-1:0] ID_EX_regWrite;
  logic [TAG_W-1:0] EX_MEM_regWrite;
  logic [TAG_W-1:0] MEM_WB_regWrite;
  logic             wb_commit;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] retired;
  logic             deadlock;

  modport master (
    output id_valid, id_writes, id_dest, stall, flush,
    input  ID_EX_regWrite, EX_MEM_regWrite, MEM_WB_regWrite,
    input  wb_commit, stall_cycles, retired, deadlock
  );

  modport slave (
    input  id_valid, id_writes, id_dest, stall, flush,
    output ID_EX_regWrite, EX_MEM_regWrite, MEM_WB_regWrite,
    output wb_commit, stall_cycles, retired, deadlock
  );
endinterface

// File: rtl/dest_tag_pipeline.sv
// Shifts destination-register tags through EX/MEM/WB for the hazard detection unit,
// inserting bubbles on stall/flush, with saturating stall/retire counters and a stall watchdog.
module dest_tag_pipeline #(
  parameter int               TAG_W     = 4,
  parameter logic [TAG_W-1:0] NULL_TAG  = '0,
  parameter int               MAX_STALL = 8,
  parameter int               CNT_W     = 16
) (
  input logic                clk,
  input logic                rst,
  dest_tag_pipeline_if.slave bus
);
  localparam int              WD_W   = $clog2(MAX_STALL + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(MAX_STALL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [WD_W-1:0] wd_next(input logic [WD_W-1:0] v, input logic stall_i);
    if (!stall_i)
      return '0;
    return (v == WD_MAX) ? v : v + WD_W'(1);
  endfunction

  logic [TAG_W-1:0] r_tag_p0;
  logic [TAG_W-1:0] r_tag_p1;
  logic [TAG_W-1:0] r_tag_p2;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] r_retired;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_deadlock;

  logic [TAG_W-1:0] w_entry;
  logic [WD_W-1:0]  w_wd_nxt;
  logic             w_commit;

  // A non-writing or register-0 destination enters as a bubble so it can never match a read.
  assign w_entry  = (bus.id_valid && bus.id_writes && (bus.id_dest != NULL_TAG)) ? bus.id_dest : NULL_TAG;
  assign w_wd_nxt = wd_next(r_wd_cnt, bus.stall);
  assign w_commit = (r_tag_p2 != NULL_TAG);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_p0       <= NULL_TAG;
      r_tag_p1       <= NULL_TAG;
      r_tag_p2       <= NULL_TAG;
      r_stall_cycles <= '0;
      r_retired      <= '0;
      r_wd_cnt       <= '0;
      r_deadlock     <= 1'b0;
    end else begin
      // EX entry: flush beats stall; both insert a bubble while upstream holds the decode entry
      r_tag_p0 <= (bus.flush || bus.stall) ? NULL_TAG : w_entry;
      // EX -> MEM
      r_tag_p1 <= r_tag_p0;
      // MEM -> WB
      r_tag_p2 <= r_tag_p1;

      if (bus.stall)
        r_stall_cycles <= sat_inc(r_stall_cycles);
      if (w_commit)
        r_retired <= sat_inc(r_retired);
      r_wd_cnt <= w_wd_nxt;
      if (bus.stall && (w_wd_nxt == WD_MAX))
        r_deadlock <= 1'b1;
    end
  end

  assign bus.ID_EX_regWrite  = r_tag_p0;
  assign bus.EX_MEM_regWrite = r_tag_p1;
  assign bus.MEM_WB_regWrite = r_tag_p2;
  assign bus.wb_commit       = w_commit;
  assign bus.stall_cycles    = r_stall_cycles;
  assign bus.retired         = r_retired;
  assign bus.deadlock        = r_deadlock;
endmodule

// File: tb/tb_dest_tag_pipeline.sv
// Directed bench for dest_tag_pipeline: a default instance (CNT_W=16) and a CNT_W=4 instance
// sharing the same stimulus, so counter saturation can be seen quickly.
module tb_dest_tag_pipeline;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  dest_tag_pipeline_if #(.TAG_W(4), .CNT_W(16)) bus ();
  dest_tag_pipeline_if #(.TAG_W(4), .CNT_W(4))  bus_s ();

  assign bus_s.id_valid  = bus.id_valid;
  assign bus_s.id_writes = bus.id_writes;
  assign bus_s.id_dest   = bus.id_dest;
  assign bus_s.stall     = bus.stall;
  assign bus_s.flush     = bus.flush;

  dest_tag_pipeline #(.TAG_W(4), .NULL_TAG(4'd0), .MAX_STALL(8), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  dest_tag_pipeline #(.TAG_W(4), .NULL_TAG(4'd0), .MAX_STALL(8), .CNT_W(4)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bus_s)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic w, input logic [3:0] d, input logic s, input logic f);
    bus.id_valid  = v;
    bus.id_writes = w;
    bus.id_dest   = d;
    bus.stall     = s;
    bus.flush     = f;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
    n_checks++;
    if ({bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite} !== 12'h000)
      $display("FAIL reset_tags got %h want 000", {bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite});
    else n_pass++;
    n_checks++;
    if (bus.stall_cycles !== 16'd0 || bus.retired !== 16'd0)
      $display("FAIL reset_counters got stall=%0d ret=%0d want 0 0", bus.stall_cycles, bus.retired);
    else n_pass++;
    n_checks++;
    if (bus.deadlock !== 1'b0 || bus.wb_commit !== 1'b0)
      $display("FAIL reset_flags got dl=%b commit=%b want 0 0", bus.deadlock, bus.wb_commit);
    else n_pass++;
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic test_streaming();
    logic [3:0]  d_tab   [6] = '{4'd3, 4'd5, 4'd7, 4'd0, 4'd0, 4'd0};
    logic [3:0]  ex_tab  [6] = '{4'd3, 4'd5, 4'd7, 4'd0, 4'd0, 4'd0};
    logic [3:0]  mem_tab [6] = '{4'd0, 4'd3, 4'd5, 4'd7, 4'd0, 4'd0};
    logic [3:0]  wb_tab  [6] = '{4'd0, 4'd0, 4'd3, 4'd5, 4'd7, 4'd0};
    logic [15:0] ret_tab [6] = '{16'd0, 16'd0, 16'd0, 16'd1, 16'd2, 16'd3};
    for (int i = 0; i < 6; i++) begin
      drive(i < 3, 1'b1, d_tab[i], 0, 0);
      tick();
      n_checks++;
      if ({bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite} !== {ex_tab[i], mem_tab[i], wb_tab[i]})
        $display("FAIL stream_tags[%0d] got %h want %h", i,
                 {bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite}, {ex_tab[i], mem_tab[i], wb_tab[i]});
      else n_pass++;
      n_checks++;
      if (bus.retired !== ret_tab[i] || bus.wb_commit !== (wb_tab[i] != 4'd0))
        $display("FAIL stream_retire[%0d] got ret=%0d commit=%b want ret=%0d commit=%b", i,
                 bus.retired, bus.wb_commit, ret_tab[i], wb_tab[i] != 4'd0);
      else n_pass++;
    end
  endtask

  task automatic test_stall_bubble();
    // Tag 2 goes in first so the downstream stages visibly keep shifting during the stall.
    logic [3:0] d_tab   [4] = '{4'd2, 4'd9, 4'd9, 4'd9};
    logic       s_tab   [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic [3:0] ex_tab  [4] = '{4'd2, 4'd0, 4'd0, 4'd9};
    logic [3:0] mem_tab [4] = '{4'd0, 4'd2, 4'd0, 4'd0};
    logic [3:0] wb_tab  [4] = '{4'd0, 4'd0, 4'd2, 4'd0};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, d_tab[i], s_tab[i], 0);
      tick();
      n_checks++;
      if ({bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite} !== {ex_tab[i], mem_tab[i], wb_tab[i]})
        $display("FAIL stall_tags[%0d] got %h want %h", i,
                 {bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite}, {ex_tab[i], mem_tab[i], wb_tab[i]});
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.stall_cycles !== 16'd2 || bus.retired !== 16'd5)
      $display("FAIL stall_counts got stall=%0d ret=%0d want 2 5", bus.stall_cycles, bus.retired);
    else n_pass++;
  endtask

  task automatic test_flush_priority();
    logic seen6 = 1'b0;
    drive(1, 1, 4'd6, 1, 1);
    tick();
    n_checks++;
    if (bus.ID_EX_regWrite !== 4'd0 || bus.stall_cycles !== 16'd3)
      $display("FAIL flush_stall got ex=%0d stall=%0d want 0 3", bus.ID_EX_regWrite, bus.stall_cycles);
    else n_pass++;
    drive(1, 1, 4'd6, 0, 1);
    tick();
    n_checks++;
    if (bus.ID_EX_regWrite !== 4'd0 || bus.stall_cycles !== 16'd3)
      $display("FAIL flush_only got ex=%0d stall=%0d want 0 3", bus.ID_EX_regWrite, bus.stall_cycles);
    else n_pass++;
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.MEM_WB_regWrite == 4'd6) seen6 = 1'b1;
    end
    n_checks++;
    if (seen6 !== 1'b0 || bus.retired !== 16'd5)
      $display("FAIL flush_squash got seen6=%b ret=%0d want 0 5", seen6, bus.retired);
    else n_pass++;
  endtask

  task automatic test_null_filter();
    logic       v_tab [3] = '{1'b1, 1'b1, 1'b0};
    logic       w_tab [3] = '{1'b0, 1'b1, 1'b1};
    logic [3:0] d_tab [3] = '{4'd4, 4'd0, 4'd4};
    for (int i = 0; i < 3; i++) begin
      drive(v_tab[i], w_tab[i], d_tab[i], 0, 0);
      tick();
      n_checks++;
      if (bus.ID_EX_regWrite !== 4'd0)
        $display("FAIL null_entry[%0d] got %0d want 0", i, bus.ID_EX_regWrite);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.retired !== 16'd5)
      $display("FAIL null_retired got %0d want 5", bus.retired);
    else n_pass++;
  endtask

  task automatic test_watchdog();
    drive(0, 0, 0, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      tick();
      n_checks++;
      if (bus.deadlock !== (i == 8))
        $display("FAIL wd_edge[%0d] got %b want %b", i, bus.deadlock, i == 8);
      else n_pass++;
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.deadlock !== 1'b1 || bus.stall_cycles !== 16'd11)
      $display("FAIL wd_sticky got dl=%b stall=%0d want 1 11", bus.deadlock, bus.stall_cycles);
    else n_pass++;
  endtask

  task automatic test_reset_midflight();
    drive(1, 1, 4'd1, 0, 0);
    tick();
    drive(1, 1, 4'd2, 1, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if ({bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite} !== 12'h000 || bus.deadlock !== 1'b0)
      $display("FAIL rst_mid_state got tags=%h dl=%b want 000 0",
               {bus.ID_EX_regWrite, bus.EX_MEM_regWrite, bus.MEM_WB_regWrite}, bus.deadlock);
    else n_pass++;
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus.retired !== 16'd0 || bus.stall_cycles !== 16'd0)
      $display("FAIL rst_mid_counts got ret=%0d stall=%0d want 0 0", bus.retired, bus.stall_cycles);
    else n_pass++;
  endtask

  task automatic test_saturation();
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 20; i++) tick();
    drive(0, 0, 0, 0, 0);
    n_checks++;
    if (bus_s.stall_cycles !== 4'd15 || bus.stall_cycles !== 16'd20)
      $display("FAIL sat_stall got small=%0d big=%0d want 15 20", bus_s.stall_cycles, bus.stall_cycles);
    else n_pass++;
    n_checks++;
    if (bus_s.deadlock !== 1'b1)
      $display("FAIL sat_deadlock got %b want 1", bus_s.deadlock);
    else n_pass++;
    for (int i = 0; i < 20; i++) begin
      drive(1, 1, 4'(i % 15 + 1), 0, 0);
      tick();
    end
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
    n_checks++;
    if (bus_s.retired !== 4'd15 || bus.retired !== 16'd20)
      $display("FAIL sat_retired got small=%0d big=%0d want 15 20", bus_s.retired, bus.retired);
    else n_pass++;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0);
    test_reset();
    test_streaming();
    test_stall_bubble();
    test_flush_priority();
    test_null_filter();
    test_watchdog();
    test_reset_midflight();
    test_saturation();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
